// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes and datapath mux/ALU codes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ORIEX  = 4'd10,
    S_ORIWB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose exit back to FETCH completes (retires) an instruction.
  function automatic logic is_retire_state(state_e s);
    return (s == S_MEMWB) || (s == S_MEMWR) || (s == S_RWB) ||
           (s == S_BRANCH) || (s == S_JUMP) || (s == S_ORIWB);
  endfunction

endpackage

// File: rtl/mc_control.sv
// Multicycle MIPS-style control FSM: Moore state decode, opcode dispatch and retired-instruction counter.
module mc_control
  import mc_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic               zext,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic [3:0]         state,
  output logic               illegal,
  output logic [COUNT_W-1:0] instr_count
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 retire;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_d = S_EXEC;
          OP_LW, OP_SW:  state_d = S_MEMADR;
          OP_BEQ:        state_d = S_BRANCH;
          OP_J:          state_d = S_JUMP;
          OP_ORI:        state_d = S_ORIEX;
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_RWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ORIEX:  state_d = S_ORIWB;
      S_ORIWB:  state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Only completed instructions count; the illegal DECODE->FETCH path is excluded by is_retire_state.
  assign retire = (state_d == S_FETCH) && is_retire_state(state_q);

  always_comb begin
    count_d = count_q;
    if (retire) count_d = count_q + COUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    irwrite     = 1'b0;
    memtoreg    = 1'b0;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    zext        = 1'b0;
    alusrcb     = SRCB_RT;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    illegal     = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ORI});
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
      end
      S_ORIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_OR;
        zext    = 1'b1;
      end
      S_ORIWB: regwrite = 1'b1;
      default: ;
    endcase
  end

  assign state       = state_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control with a 4-bit retired-instruction counter.
module tb_mc_control;

  localparam int CW = 4;

  // Expected control words {pcwrite,pcwritecond,iord,memread,memwrite,irwrite,
  // memtoreg,regdst,regwrite,alusrca,zext,alusrcb,aluop,pcsource}.
  localparam logic [16:0] C_FETCH1 = 17'b1_0_0_1_0_1_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_FETCH0 = 17'b0_0_0_1_0_0_0_0_0_0_0_01_00_00;
  localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
  localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_0_10_00_00;
  localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_0_00_00_00;
  localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_0_00_00_00;
  localparam logic [16:0] C_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_0_00_10_00;
  localparam logic [16:0] C_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_0_00_00_00;
  localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_0_00_01_01;
  localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_0_00_00_10;
  localparam logic [16:0] C_ORIEX  = 17'b0_0_0_0_0_0_0_0_0_1_1_10_11_00;
  localparam logic [16:0] C_ORIWB  = 17'b0_0_0_0_0_0_0_0_1_0_0_00_00_00;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic mem_ready = 1'b0;
  logic pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic memtoreg, regdst, regwrite, alusrca, zext;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;
  logic illegal;
  logic [CW-1:0] instr_count;
  logic [16:0] ctrl;

  int total = 0;
  int bad = 0;

  mc_control #(.COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .zext(zext), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  assign ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                 memtoreg, regdst, regwrite, alusrca, zext, alusrcb, aluop, pcsource};

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 6'd0;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
    total++; if (ctrl !== C_FETCH0) begin bad++; $display("FAIL reset_ctrl got=%b want=%b", ctrl, C_FETCH0); end
    total++; if (instr_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
  endtask

  task automatic test_rtype();
    logic [3:0]  st [5];
    logic [16:0] ex [5];
    st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    ex = '{C_FETCH1, C_DECODE, C_EXEC, C_RWB, C_FETCH1};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL rtype_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL rtype_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      if (i < 4) cyc();
    end
    total++; if (instr_count !== 4'd1) begin bad++; $display("FAIL rtype_count got=%0d want=1", instr_count); end
  endtask

  task automatic test_lw_wait();
    logic [3:0]  st [9];
    logic [16:0] ex [9];
    logic        mr [9];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd0};
    ex = '{C_FETCH1, C_DECODE, C_MEMADR, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMRD, C_MEMWB, C_FETCH1};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      // opcode is scrambled once past MEMADR; the FSM must ignore it there
      opcode = (i < 3) ? 6'b100011 : 6'b111111;
      mem_ready = mr[i];
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL lw_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      total++; if (illegal !== 1'b0) begin bad++; $display("FAIL lw_illegal[%0d] got=%b want=0", i, illegal); end
      if (i < 8) cyc();
    end
    total++; if (instr_count !== 4'd2) begin bad++; $display("FAIL lw_count got=%0d want=2", instr_count); end
  endtask

  task automatic test_illegal();
    logic [3:0]  st [4];
    logic [16:0] ex [4];
    logic        il [4];
    st = '{4'd0, 4'd1, 4'd0, 4'd1};
    ex = '{C_FETCH1, C_DECODE, C_FETCH1, C_DECODE};
    il = '{1'b0, 1'b1, 1'b0, 1'b0};
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      opcode = (i < 3) ? 6'b111111 : 6'b000010;
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL illegal_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL illegal_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      total++; if (illegal !== il[i]) begin bad++; $display("FAIL illegal_flag[%0d] got=%b want=%b", i, illegal, il[i]); end
      total++; if (instr_count !== 4'd2) begin bad++; $display("FAIL illegal_count[%0d] got=%0d want=2", i, instr_count); end
      if (i < 3) cyc();
    end
    cyc();
    total++; if (state !== 4'd9) begin bad++; $display("FAIL illegal_tojump got=%0d want=9", state); end
    cyc();
    total++; if (instr_count !== 4'd3) begin bad++; $display("FAIL illegal_jcount got=%0d want=3", instr_count); end
  endtask

  task automatic test_reset_in_memwr();
    logic [3:0]  st [5];
    logic [16:0] ex [5];
    logic        mr [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5};
    ex = '{C_FETCH1, C_DECODE, C_MEMADR, C_MEMWR, C_MEMWR};
    mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    opcode = 6'b101011;
    for (int i = 0; i < 5; i++) begin
      mem_ready = mr[i];
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL swrst_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL swrst_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      if (i < 4) cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    #1;
    total++; if (state !== 4'd0) begin bad++; $display("FAIL swrst_after_state got=%0d want=0", state); end
    total++; if (memwrite !== 1'b0) begin bad++; $display("FAIL swrst_memwrite got=%b want=0", memwrite); end
    total++; if (ctrl !== C_FETCH0) begin bad++; $display("FAIL swrst_ctrl got=%b want=%b", ctrl, C_FETCH0); end
    total++; if (instr_count !== 4'd0) begin bad++; $display("FAIL swrst_count got=%0d want=0", instr_count); end
  endtask

  task automatic test_branch_ori();
    logic [3:0]  st [8];
    logic [16:0] ex [8];
    st = '{4'd0, 4'd1, 4'd8, 4'd0, 4'd1, 4'd10, 4'd11, 4'd0};
    ex = '{C_FETCH1, C_DECODE, C_BRANCH, C_FETCH1, C_DECODE, C_ORIEX, C_ORIWB, C_FETCH1};
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 3) ? 6'b000100 : 6'b001101;
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL brori_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL brori_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      if (i < 7) cyc();
    end
    total++; if (instr_count !== 4'd2) begin bad++; $display("FAIL brori_count got=%0d want=2", instr_count); end
  endtask

  task automatic test_wrap();
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    opcode = 6'b000010; mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      cyc();
      cyc();
      total++; if (state !== 4'd9) begin bad++; $display("FAIL wrap_state[%0d] got=%0d want=9", k, state); end
      total++; if (ctrl !== C_JUMP) begin bad++; $display("FAIL wrap_ctrl[%0d] got=%b want=%b", k, ctrl, C_JUMP); end
      cyc();
      if (k == 14) begin
        total++; if (instr_count !== 4'd15) begin bad++; $display("FAIL wrap_preload got=%0d want=15", instr_count); end
      end
    end
    total++; if (instr_count !== 4'd0) begin bad++; $display("FAIL wrap_count got=%0d want=0", instr_count); end
    total++; if (state !== 4'd0) begin bad++; $display("FAIL wrap_end_state got=%0d want=0", state); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  st [7];
    logic [16:0] ex [7];
    logic        mr [7];
    st = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    ex = '{C_FETCH0, C_FETCH0, C_FETCH1, C_DECODE, C_MEMADR, C_MEMWR, C_FETCH1};
    mr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    opcode = 6'b101011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = mr[i];
      #1;
      total++; if (state !== st[i]) begin bad++; $display("FAIL b2b_state[%0d] got=%0d want=%0d", i, state, st[i]); end
      total++; if (ctrl !== ex[i]) begin bad++; $display("FAIL b2b_ctrl[%0d] got=%b want=%b", i, ctrl, ex[i]); end
      if (i < 6) cyc();
    end
    total++; if (instr_count !== 4'd1) begin bad++; $display("FAIL b2b_count got=%0d want=1", instr_count); end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_illegal();
    test_reset_in_memwr();
    test_branch_ori();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
